// File: rtl/axi_pkg.sv
// Shared AXI master definitions: bus widths, fixed AR attributes,
// and the read-arbiter FSM state encoding.
package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } rd_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; on a tie the requester that did not
// win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master between fetch (0) and load/DMA (1),
// one burst at a time, with R beats routed back to the winner.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ID_BITS   = AXI_ID_BITS,
  parameter int ADDR_BITS = AXI_ADDR_BITS,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int LEN_BITS  = AXI_LEN_BITS
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [1:0]           req_valid,
  input  logic [ADDR_BITS-1:0] req_addr0,
  input  logic [ADDR_BITS-1:0] req_addr1,
  input  logic [LEN_BITS-1:0]  req_len0,
  input  logic [LEN_BITS-1:0]  req_len1,
  output logic [1:0]           req_ack,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [1:0]           rsp_resp,
  output logic                 rsp_last,
  input  logic                 wr_busy,
  output logic                 busy,
  output logic [ID_BITS-1:0]   ARID,
  output logic [ADDR_BITS-1:0] ARADDR,
  output logic [LEN_BITS-1:0]  ARLEN,
  output logic [2:0]           ARSIZE,
  output logic [1:0]           ARBURST,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [ID_BITS-1:0]   RID,
  input  logic [DATA_BITS-1:0] RDATA,
  input  logic [1:0]           RRESP,
  input  logic                 RLAST,
  input  logic                 RVALID,
  output logic                 RREADY
);

  rd_arb_state_t        state_q, state_d;
  logic                 win_q, win_d;
  logic                 last_q, last_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [1:0]           gnt;
  logic                 grant_en;
  logic                 unused_rid;

  // Single outstanding burst, so RID carries no routing information.
  assign unused_rid = ^RID;

  rr_arbiter2 u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .gnt        (gnt)
  );

  assign grant_en = (state_q == IDLE) && !wr_busy && (|req_valid);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    addr_d  = addr_q;
    len_d   = len_q;
    req_ack = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          req_ack = gnt;
          win_d   = gnt[1];
          last_d  = gnt[1];
          addr_d  = gnt[1] ? req_addr1 : req_addr0;
          len_d   = gnt[1] ? req_len1 : req_len0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ARREADY) state_d = DATA;
      end
      DATA: begin
        if (RVALID && RREADY && RLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  assign ARVALID = (state_q == ADDR);
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARID    = {{(ID_BITS-1){1'b0}}, win_q};
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign busy    = (state_q != IDLE);

  assign RREADY  = (state_q == DATA) && rsp_ready[win_q];

  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == DATA) rsp_valid[win_q] = RVALID;
  end

  assign rsp_data = RDATA;
  assign rsp_resp = RRESP;
  assign rsp_last = RLAST;

endmodule
